// File: rtl/gelato_pc_table.sv
// gelato_pc_table: per-warp PC / thread-mask table with a round-robin fetch
// scheduler. Each warp cycles IDLE -> READY -> WAIT -> READY/IDLE. One READY
// warp per cycle is moved into a registered output slot that is offered to
// the instruction fetch unit over a valid/ready handshake.
module gelato_pc_table #(
  parameter int WARP_NUM   = 8,
  parameter int THREAD_NUM = 32,
  parameter int ADDR_WIDTH = 32,
  localparam int WARP_IDX_W = $clog2(WARP_NUM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // warp launch
  input  logic                  launch_valid,
  input  logic [WARP_IDX_W-1:0] launch_warp,
  input  logic [ADDR_WIDTH-1:0] launch_pc,
  input  logic [THREAD_NUM-1:0] launch_mask,
  // post-execution PC / mask update
  input  logic                  update_valid,
  input  logic [WARP_IDX_W-1:0] update_warp,
  input  logic [ADDR_WIDTH-1:0] update_pc,
  input  logic [THREAD_NUM-1:0] update_mask,
  input  logic                  update_exit,
  // fetch request
  output logic                  ifetch_valid,
  input  logic                  ifetch_ready,
  output logic [ADDR_WIDTH-1:0] ifetch_pc,
  output logic [WARP_IDX_W-1:0] ifetch_warp_num,
  output logic [THREAD_NUM-1:0] ifetch_thread_mask,
  // status
  output logic [WARP_NUM-1:0]   warp_active,
  output logic                  all_idle
);

  typedef enum logic [1:0] {
    WARP_IDLE  = 2'd0,
    WARP_READY = 2'd1,
    WARP_WAIT  = 2'd2
  } warp_state_e;

  // Output slot and round-robin pointer
  logic                  ifetch_valid_q;
  logic [ADDR_WIDTH-1:0] ifetch_pc_q;
  logic [WARP_IDX_W-1:0] ifetch_warp_q;
  logic [THREAD_NUM-1:0] ifetch_mask_q;
  logic [WARP_IDX_W-1:0] rr_ptr_q;

  // Flattened views of the per-warp registers for the scheduler mux
  logic [WARP_NUM-1:0]   ready_vec;
  logic [ADDR_WIDTH-1:0] warp_pc   [WARP_NUM];
  logic [THREAD_NUM-1:0] warp_mask [WARP_NUM];

  // Scheduler decisions
  logic                  slot_load;
  logic                  pick_found;
  logic [WARP_IDX_W-1:0] pick_idx;
  logic                  pick_fire;

  // The slot may take a new request when empty or when its content leaves now
  assign slot_load = !ifetch_valid_q || ifetch_ready;
  assign pick_fire = slot_load && pick_found;

  // Round-robin pick: first READY warp scanning cyclically from rr_ptr+1.
  // The last candidate (i == WARP_NUM) wraps back onto rr_ptr itself.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr_q;
    for (int i = 1; i <= WARP_NUM; i++) begin
      if (!pick_found && ready_vec[rr_ptr_q + WARP_IDX_W'(i)]) begin
        pick_found = 1'b1;
        pick_idx   = rr_ptr_q + WARP_IDX_W'(i);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < WARP_NUM; gi++) begin : g_warp
      warp_state_e           state_q, state_d;
      logic [ADDR_WIDTH-1:0] pc_q, pc_d;
      logic [THREAD_NUM-1:0] mask_q, mask_d;
      logic                  launch_hit;
      logic                  update_hit;
      logic                  picked;

      assign launch_hit = launch_valid && (launch_warp == WARP_IDX_W'(gi));
      assign update_hit = update_valid && (update_warp == WARP_IDX_W'(gi));
      assign picked     = pick_fire && (pick_idx == WARP_IDX_W'(gi));

      // Next-state for one warp. Launch only acts on IDLE, pick only on
      // READY and update only on WAIT, so the three never collide.
      always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mask_d  = mask_q;
        case (state_q)
          WARP_IDLE: begin
            if (launch_hit) begin
              pc_d   = launch_pc;
              mask_d = launch_mask;
              if (launch_mask != '0) begin
                state_d = WARP_READY;
              end
            end
          end
          WARP_READY: begin
            if (picked) begin
              state_d = WARP_WAIT;
            end
          end
          WARP_WAIT: begin
            if (update_hit) begin
              if (update_exit || (update_mask == '0)) begin
                state_d = WARP_IDLE;
              end else begin
                pc_d    = update_pc;
                mask_d  = update_mask;
                state_d = WARP_READY;
              end
            end
          end
          default: state_d = WARP_IDLE;
        endcase
      end

      // Per-warp state, PC and mask registers
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_q <= WARP_IDLE;
          pc_q    <= '0;
          mask_q  <= '0;
        end else begin
          state_q <= state_d;
          pc_q    <= pc_d;
          mask_q  <= mask_d;
        end
      end

      assign ready_vec[gi]   = (state_q == WARP_READY);
      assign warp_active[gi] = (state_q != WARP_IDLE);
      assign warp_pc[gi]     = pc_q;
      assign warp_mask[gi]   = mask_q;
    end
  endgenerate

  // Output slot: refill from the picked warp, or drain when nothing is READY.
  // While the slot is held (valid && !ready) both it and rr_ptr stay put.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ifetch_valid_q <= 1'b0;
      ifetch_pc_q    <= '0;
      ifetch_warp_q  <= '0;
      ifetch_mask_q  <= '0;
      rr_ptr_q       <= WARP_IDX_W'(WARP_NUM - 1);
    end else if (slot_load) begin
      ifetch_valid_q <= pick_found;
      if (pick_found) begin
        ifetch_pc_q   <= warp_pc[pick_idx];
        ifetch_warp_q <= pick_idx;
        ifetch_mask_q <= warp_mask[pick_idx];
        rr_ptr_q      <= pick_idx;
      end
    end
  end

  assign ifetch_valid       = ifetch_valid_q;
  assign ifetch_pc          = ifetch_pc_q;
  assign ifetch_warp_num    = ifetch_warp_q;
  assign ifetch_thread_mask = ifetch_mask_q;
  assign all_idle           = ~|warp_active;

endmodule
